// File: rtl/lw_hmac_multislot.sv
// HMAC sequencer: inner pass H((K^ipad)||msg), outer pass H((K^opad)||inner), with saved key slots.
// The core pads each pass on core_last_o; done_o follows the outer core_done_i by one cycle.
module lw_hmac_multislot #(
  parameter int WORD_W       = 32,
  parameter int BLOCK_WORDS  = 16,
  parameter int DIGEST_WORDS = 8,
  parameter int NUM_SLOTS    = 4,
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int KLEN_W = $clog2(BLOCK_WORDS + 1)
) (
  input  logic                           clk_i,
  input  logic                           aresetn_i,
  input  logic                           start_i,
  input  logic                           abort_i,
  input  logic [SLOT_W-1:0]              slot_i,
  input  logic                           key_reuse_i,
  input  logic                           key_save_i,
  input  logic [KLEN_W-1:0]              key_len_i,
  input  logic [WORD_W-1:0]              key_i,
  input  logic                           key_valid_i,
  output logic                           key_ready_o,
  input  logic [WORD_W-1:0]              data_i,
  input  logic                           data_valid_i,
  input  logic                           data_last_i,
  output logic                           data_ready_o,
  output logic                           core_start_o,
  output logic [WORD_W-1:0]              core_data_o,
  output logic                           core_valid_o,
  output logic                           core_last_o,
  input  logic                           core_ready_i,
  input  logic                           core_done_i,
  input  logic [DIGEST_WORDS*WORD_W-1:0] core_digest_i,
  output logic [DIGEST_WORDS*WORD_W-1:0] hash_o,
  output logic                           done_o,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int IDX_W  = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int DIG_IW = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;
  localparam logic [WORD_W-1:0] IPAD_PAT = {(WORD_W/8){8'h36}};
  localparam logic [WORD_W-1:0] OPAD_PAT = {(WORD_W/8){8'h5c}};
  localparam logic [IDX_W-1:0]  BLK_LAST = IDX_W'(BLOCK_WORDS - 1);
  localparam logic [IDX_W-1:0]  DIG_LAST = IDX_W'(DIGEST_WORDS - 1);

  typedef enum logic [2:0] {IDLE, KEY, IPAD, MSG, WAIT_I, OPAD, DIG, WAIT_O} state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [KLEN_W-1:0]    klen;
  logic [SLOT_W-1:0]    slot;
  logic                 save;
  logic [WORD_W-1:0]    buffer [BLOCK_WORDS];
  logic [WORD_W-1:0]    slots  [NUM_SLOTS][BLOCK_WORDS];
  logic [NUM_SLOTS-1:0] slot_valid;
  logic [WORD_W-1:0]    inner  [DIGEST_WORDS];
  logic [IDX_W-1:0]     last_key_idx;

  assign last_key_idx = IDX_W'(klen - KLEN_W'(1));
  assign busy_o       = (state != IDLE);

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state        <= IDLE;
      idx          <= '0;
      klen         <= '0;
      slot         <= '0;
      save         <= 1'b0;
      slot_valid   <= '0;
      hash_o       <= '0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      core_start_o <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) buffer[i] <= '0;
      for (int i = 0; i < DIGEST_WORDS; i++) inner[i] <= '0;
      for (int s = 0; s < NUM_SLOTS; s++)
        for (int i = 0; i < BLOCK_WORDS; i++) slots[s][i] <= '0;
    end else begin
      core_start_o <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      if (abort_i) begin
        state <= IDLE;
        idx   <= '0;
        for (int i = 0; i < BLOCK_WORDS; i++) buffer[i] <= '0;
        for (int i = 0; i < DIGEST_WORDS; i++) inner[i] <= '0;
      end else begin
        case (state)
          IDLE: if (start_i) begin
            idx  <= '0;
            klen <= key_len_i;
            slot <= slot_i;
            save <= key_save_i;
            if (key_len_i == '0 || (key_reuse_i && !slot_valid[slot_i])) begin
              err_o <= 1'b1;
            end else if (key_reuse_i) begin
              for (int i = 0; i < BLOCK_WORDS; i++) buffer[i] <= slots[slot_i][i];
              core_start_o <= 1'b1;
              state        <= IPAD;
            end else begin
              for (int i = 0; i < BLOCK_WORDS; i++) buffer[i] <= '0;
              state <= KEY;
            end
          end
          KEY: if (key_valid_i) begin
            buffer[idx] <= key_i;
            if (idx == last_key_idx) begin
              idx          <= '0;
              core_start_o <= 1'b1;
              state        <= IPAD;
              // The final key word is still in flight, so merge it into the slot copy directly.
              if (save) begin
                slot_valid[slot] <= 1'b1;
                for (int i = 0; i < BLOCK_WORDS; i++)
                  slots[slot][i] <= (IDX_W'(i) == idx) ? key_i : buffer[i];
              end
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          IPAD, OPAD: if (core_ready_i) begin
            if (idx == BLK_LAST) begin
              idx   <= '0;
              state <= (state == IPAD) ? MSG : DIG;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          MSG: if (data_valid_i && core_ready_i && data_last_i) state <= WAIT_I;
          WAIT_I: if (core_done_i) begin
            for (int i = 0; i < DIGEST_WORDS; i++)
              inner[i] <= core_digest_i[(DIGEST_WORDS-1-i)*WORD_W +: WORD_W];
            core_start_o <= 1'b1;
            state        <= OPAD;
          end
          DIG: if (core_ready_i) begin
            if (idx == DIG_LAST) begin
              idx   <= '0;
              state <= WAIT_O;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          WAIT_O: if (core_done_i) begin
            hash_o <= core_digest_i;
            done_o <= 1'b1;
            for (int i = 0; i < BLOCK_WORDS; i++) buffer[i] <= '0;
            for (int i = 0; i < DIGEST_WORDS; i++) inner[i] <= '0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    key_ready_o  = (state == KEY);
    data_ready_o = 1'b0;
    core_data_o  = '0;
    core_valid_o = 1'b0;
    core_last_o  = 1'b0;
    case (state)
      IPAD: begin
        core_data_o  = buffer[idx] ^ IPAD_PAT;
        core_valid_o = 1'b1;
      end
      OPAD: begin
        core_data_o  = buffer[idx] ^ OPAD_PAT;
        core_valid_o = 1'b1;
      end
      MSG: begin
        core_data_o  = data_i;
        core_valid_o = data_valid_i;
        core_last_o  = data_last_i;
        data_ready_o = core_ready_i;
      end
      DIG: begin
        core_data_o  = inner[DIG_IW'(idx)];
        core_valid_o = 1'b1;
        core_last_o  = (idx == DIG_LAST);
      end
      default: ;
    endcase
  end

endmodule
